// File: rtl/sram_port0_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sram_port0_ctrl                                               |
// | Purpose  : Single-clock initiator for the 1RW port (port 0) of an        |
// |            OpenRAM SRAM macro. Turns valid/ready requests into timed     |
// |            csb0/web0/addr0/din0 cycles and returns read data on a fixed  |
// |            2-cycle response strobe.                                      |
// | Option   : SRAM_CTRL_INIT_EN - when defined, a post-reset sweep writes   |
// |            INIT_VALUE to every word before traffic is accepted.          |
// | Ports    : clk0/rstb0         clock, synchronous active-low reset        |
// |            req_valid/req_ready/req_we/req_addr/req_wdata  request side   |
// |            rsp_valid/rsp_data response strobe and captured read data     |
// |            init_done          high once the controller is in RUN         |
// |            csb0/web0/addr0/din0/dout0  SRAM port 0 pins                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sram_port0_ctrl #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk0,
  input  logic                  rstb0,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  init_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  // All outputs come straight from flops.
  logic                  csb0_q, csb0_d;
  logic                  web0_q, web0_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
  logic [DATA_WIDTH-1:0] din0_q, din0_d;
  logic                  req_ready_q, req_ready_d;
  logic                  init_done_q, init_done_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  // Bit 0: read pins driven this cycle; bit 1: SRAM sampled the read, dout0
  // settles in this cycle and is captured at the following edge.
  logic [1:0]            rd_pipe_q, rd_pipe_d;
  logic                  w_run;
  logic                  w_accept;

`ifdef SRAM_CTRL_INIT_EN
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] c_addr_last = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] c_addr_one  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  assign w_run = (state_q == ST_RUN);
`else
  assign w_run = 1'b1;
`endif

  // req_ready_q is only ever set in RUN, so it alone qualifies an accept.
  assign w_accept = req_valid && req_ready_q;

  always_comb begin
    csb0_d      = 1'b1;
    web0_d      = 1'b1;
    addr0_d     = addr0_q;
    din0_d      = din0_q;
    req_ready_d = w_run;
    init_done_d = w_run;
    rd_pipe_d   = {rd_pipe_q[0], w_accept && !req_we};
    rsp_valid_d = rd_pipe_q[1];
    // dout0 is X right after each posedge except when a read has settled,
    // so it is only looked at on the capture edge.
    rsp_data_d  = rd_pipe_q[1] ? dout0 : rsp_data_q;
`ifdef SRAM_CTRL_INIT_EN
    state_d     = state_q;
    cnt_d       = cnt_q;
    if (state_q == ST_INIT) begin
      csb0_d  = 1'b0;
      web0_d  = 1'b0;
      addr0_d = cnt_q;
      din0_d  = INIT_VALUE;
      // Leave on the last address instead of wrapping the counter.
      if (cnt_q == c_addr_last) begin
        state_d = ST_RUN;
      end else begin
        cnt_d = cnt_q + c_addr_one;
      end
    end else
`endif
    if (w_accept) begin
      csb0_d  = 1'b0;
      web0_d  = !req_we;
      addr0_d = req_addr;
      din0_d  = req_wdata;
    end
  end

  always_ff @(posedge clk0) begin
    if (!rstb0) begin
      csb0_q      <= 1'b1;
      web0_q      <= 1'b1;
      addr0_q     <= '0;
      din0_q      <= '0;
      req_ready_q <= 1'b0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rd_pipe_q   <= 2'b00;
`ifdef SRAM_CTRL_INIT_EN
      state_q     <= ST_INIT;
      cnt_q       <= '0;
`endif
    end else begin
      csb0_q      <= csb0_d;
      web0_q      <= web0_d;
      addr0_q     <= addr0_d;
      din0_q      <= din0_d;
      req_ready_q <= req_ready_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rd_pipe_q   <= rd_pipe_d;
`ifdef SRAM_CTRL_INIT_EN
      state_q     <= state_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign csb0      = csb0_q;
  assign web0      = web0_q;
  assign addr0     = addr0_q;
  assign din0      = din0_q;
  assign req_ready = req_ready_q;
  assign init_done = init_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule
`default_nettype wire

// File: doc/sram_port0_ctrl.md
# sram_port0_ctrl

Single-clock initiator that drives the 1RW port (port 0) of the OpenRAM-generated SRAM macros (default 1024 x 8). Requests arrive on a valid/ready interface and become correctly timed csb0/web0/addr0/din0 cycles. Read data is captured from dout0 and returned on a fixed-latency response strobe. An optional post-reset sequencer writes a known value to every word before accepting traffic.

## Interface
Parameters:
- DATA_WIDTH, 8, word width; must match the macro.
- ADDR_WIDTH, 10, address width; RAM_DEPTH = 1 << ADDR_WIDTH.
- INIT_VALUE, {DATA_WIDTH{1'b0}}, word written by the init sequencer.

Ports:
- clk0  input  1  clock; the same net drives the SRAM clk0.
- rstb0  input  1  reset; synchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  request can be accepted this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  word address.
- req_wdata  input  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  output  1  one-cycle strobe; rsp_data is valid.
- rsp_data  output  DATA_WIDTH  read data.
- init_done  output  1  high once the controller is in RUN.
- csb0  output  1  SRAM chip select, active-low.
- web0  output  1  SRAM write enable, active-low.
- addr0  output  ADDR_WIDTH  SRAM address.
- din0  output  DATA_WIDTH  SRAM write data.
- dout0  input  DATA_WIDTH  SRAM read data.

## Operation
- States: INIT (only when the macro is defined) and RUN. Reset enters INIT if the macro is defined, otherwise RUN.
- Reset values (all outputs driven from flops):
  - csb0=1, web0=1, addr0=0, din0=0
  - req_ready=0, rsp_valid=0, rsp_data=0, init_done=0
- INIT: an ADDR_WIDTH-bit counter issues one write per cycle, counting 0 to RAM_DEPTH-1 with din0=INIT_VALUE. After the write to RAM_DEPTH-1 is issued, the block moves to RUN. The counter must not wrap, and the block issues no extra write.
- RUN:
  - init_done=1 and req_ready=1 every cycle; there is no backpressure and no response stall.
  - Accept = req_valid && req_ready at a posedge. On accept, the next-cycle SRAM pins are csb0=0, web0=!req_we, addr0=req_addr, din0=req_wdata.
  - With no accept: csb0=1 and web0=1. addr0 and din0 hold their previous values.
- Reads are tracked in a 2-deep valid pipeline. Back-to-back reads give one response per cycle, in request order.
- Responses:
  - rsp_data is captured from dout0 only at the edge where the tracked read completes.
  - rsp_data holds that value until the next read completes.
  - dout0 is never sampled outside the capture edge, because the macro drives X shortly after each posedge.
- Writes produce no response.
- Reset asserted mid-operation:
  - In-flight reads are discarded and rsp_valid=0 from the next cycle.
  - An INIT sweep restarts from address 0.

## Timing
- Request accepted at edge k. The SRAM pins are valid from edge k through edge k+1, and the SRAM samples them at k+1.
- Writes commit at the SRAM negedge within cycle k+1.
- Read latency:
  - dout0 settles within cycle k+1 and is captured at edge k+2.
  - rsp_valid is high for exactly the cycle following edge k+2.
  - Read latency is therefore 2 cycles, fixed.
- Same-address write at k, then read at k+1: the read returns the new data. The write commits at the negedge of cycle k+1 and the read is sampled at k+2.
- One operation per cycle; the throughput ceiling is 1.
- INIT lasts exactly RAM_DEPTH cycles after reset release. init_done rises on the edge after the last INIT write is issued.

## Configuration
- SRAM_CTRL_INIT_EN defined:
  - The INIT state and address counter are compiled in.
  - req_ready and init_done stay 0 for RAM_DEPTH cycles after reset release.
  - Every word then reads INIT_VALUE until it is written.
- SRAM_CTRL_INIT_EN undefined:
  - No INIT logic.
  - RUN is entered on the first edge with rstb0=1, and init_done and req_ready rise on that edge.
  - Unwritten SRAM contents stay X.

## Test plan
- Reset then release with the macro defined and INIT_VALUE=8'hA5: exactly 1024 write cycles on addresses 0..1023, then init_done=1. A read of 10'h3FF returns 8'hA5.
- Write 8'h3C to 10'h005 at edge k, read 10'h005 at edge k+1: rsp_valid is high only in the cycle after edge k+3, with rsp_data=8'h3C.
- Reads of 10'h001, 10'h002, 10'h003 on consecutive cycles, after writing 8'h11, 8'h22, 8'h33 to them: three consecutive rsp_valid pulses carrying 8'h11, 8'h22, 8'h33.
- Idle for 5 cycles after traffic: csb0=1, web0=1 and rsp_valid=0 throughout, and rsp_data keeps its last value.
- rstb0 low for one cycle while two reads are in flight: no rsp_valid pulse follows. With the macro defined, the INIT sweep restarts at address 0.
- Macro undefined: init_done=1 and req_ready=1 one edge after reset release. A write followed by a read of 10'h200 returns the written 8'hC3.
